// File: rtl/pipelined_controller_if.sv
// Bus between the RV32I(M) control unit and the 5-stage datapath / hazard unit.
// master = datapath + hazard unit side (drives decode fields and hazard controls),
// slave  = pipelined_controller (drives the per-stage control bundle).
//
// Hazard semantics (no valid/ready pair on this bus): on each rising edge FlushE
// turns the E register into a bubble and wins over everything; otherwise StallE
// or MdStall freezes the E register and sends a bubble into M; otherwise E loads
// the D-stage decode. M and W advance every cycle.
interface pipelined_controller_if #(
  parameter int ALUCTRL_W = 4,
  parameter int IMMSRC_W  = 3
);
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic                 StallE;
  logic                 FlushE;
  logic                 IllegalD;
  logic [IMMSRC_W-1:0]  ImmSrcD;
  logic                 RegWriteE, RegWriteM, RegWriteW;
  logic [1:0]           ResultSrcE, ResultSrcM, ResultSrcW;
  logic                 MemWriteE, MemWriteM;
  logic                 JumpE, BranchE, ALUSrcE, SrcAsrcE, jumpRegE;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic                 MdSelE;
  logic [2:0]           MdOpE;
  logic                 MdStall;
  // divider FSM state (0 idle, 1 busy, 2 done); constant 0 without M extension
  logic [1:0]           div_state_dbg;

  modport master (
    output opcode, funct3, funct7, StallE, FlushE,
    input  IllegalD, ImmSrcD, RegWriteE, RegWriteM, RegWriteW,
    input  ResultSrcE, ResultSrcM, ResultSrcW, MemWriteE, MemWriteM,
    input  JumpE, BranchE, ALUSrcE, SrcAsrcE, jumpRegE, ALUControlE,
    input  MdSelE, MdOpE, MdStall, div_state_dbg
  );

  modport slave (
    input  opcode, funct3, funct7, StallE, FlushE,
    output IllegalD, ImmSrcD, RegWriteE, RegWriteM, RegWriteW,
    output ResultSrcE, ResultSrcM, ResultSrcW, MemWriteE, MemWriteM,
    output JumpE, BranchE, ALUSrcE, SrcAsrcE, jumpRegE, ALUControlE,
    output MdSelE, MdOpE, MdStall, div_state_dbg
  );
endinterface

// File: rtl/pipelined_controller.sv
// RV32I(M) pipelined control unit: combinational decode in D, control bundle
// registered through E/M/W, and a busy FSM that holds a divide in E.
// Optional M extension: define MEXT_EN to decode funct7=0000001 OP encodings as
// multiply/divide and to build the divider FSM; otherwise they are illegal.
module pipelined_controller #(
  parameter int ALUCTRL_W  = 4,
  parameter int IMMSRC_W   = 3,
  parameter int DIV_CYCLES = 33
) (
  input logic clk,
  input logic rst_n,
  pipelined_controller_if.slave bus
);
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [IMMSRC_W-1:0] IMM_I = IMMSRC_W'(0);
  localparam logic [IMMSRC_W-1:0] IMM_S = IMMSRC_W'(1);
  localparam logic [IMMSRC_W-1:0] IMM_B = IMMSRC_W'(2);
  localparam logic [IMMSRC_W-1:0] IMM_J = IMMSRC_W'(3);
  localparam logic [IMMSRC_W-1:0] IMM_U = IMMSRC_W'(4);

  localparam logic [ALUCTRL_W-1:0] ALU_ADD   = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB   = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND   = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_OR    = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_XOR   = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT   = ALUCTRL_W'(5);
  localparam logic [ALUCTRL_W-1:0] ALU_SLTU  = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] ALU_SLL   = ALUCTRL_W'(7);
  localparam logic [ALUCTRL_W-1:0] ALU_SRL   = ALUCTRL_W'(8);
  localparam logic [ALUCTRL_W-1:0] ALU_SRA   = ALUCTRL_W'(9);
  localparam logic [ALUCTRL_W-1:0] ALU_PASSB = ALUCTRL_W'(10);

  typedef struct packed {
    logic                 reg_write;
    logic [1:0]           result_src;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic                 alu_src;
    logic                 src_a_src;
    logic                 jump_reg;
    logic [ALUCTRL_W-1:0] alu_ctrl;
  } ctrl_t;

  ctrl_t                dec_d, e_q, e_d;
  logic                 illegal_d;
  logic [IMMSRC_W-1:0]  imm_src_d;
  logic [ALUCTRL_W-1:0] alu_f3;
  logic                 f7_base, f7_alt;
  logic [3:0]           m_q, m_d;   // {reg_write, result_src, mem_write}
  logic [2:0]           w_q, w_d;   // {reg_write, result_src}
  logic                 md_stall;
  logic                 hold_e;
`ifdef MEXT_EN
  logic                 md_sel_dec, md_sel_q, md_sel_d;
  logic [2:0]           md_op_dec, md_op_q, md_op_d;
`endif

  // D-stage decode; an illegal encoding collapses to a NOP bundle
  always_comb begin
    dec_d     = '0;
    illegal_d = 1'b0;
    imm_src_d = IMM_I;
    alu_f3    = ALU_ADD;
    f7_base   = (bus.funct7 == 7'b0000000);
    f7_alt    = (bus.funct7 == 7'b0100000);
`ifdef MEXT_EN
    md_sel_dec = 1'b0;
    md_op_dec  = 3'b000;
`endif
    case (bus.funct3)
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      3'b111:  alu_f3 = ALU_AND;
      default: alu_f3 = ALU_ADD;
    endcase
    case (bus.opcode)
      OPC_LOAD: begin
        dec_d.reg_write  = 1'b1;
        dec_d.result_src = 2'b01;
        dec_d.alu_src    = 1'b1;
      end
      OPC_STORE: begin
        dec_d.mem_write = 1'b1;
        dec_d.alu_src   = 1'b1;
        imm_src_d       = IMM_S;
      end
      OPC_OP: begin
        dec_d.reg_write = 1'b1;
        if (f7_base) dec_d.alu_ctrl = alu_f3;
        else if (f7_alt && bus.funct3 == 3'b000) dec_d.alu_ctrl = ALU_SUB;
        else if (f7_alt && bus.funct3 == 3'b101) dec_d.alu_ctrl = ALU_SRA;
`ifdef MEXT_EN
        else if (bus.funct7 == 7'b0000001) begin
          dec_d.result_src = 2'b11;
          md_sel_dec       = 1'b1;
          md_op_dec        = bus.funct3;
        end
`endif
        else illegal_d = 1'b1;
      end
      OPC_OPIMM: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_src   = 1'b1;
        dec_d.alu_ctrl  = alu_f3;
        // only the shift-immediates carry funct7; srai is told apart by funct7[5]
        if (bus.funct3 == 3'b001 && !f7_base) illegal_d = 1'b1;
        if (bus.funct3 == 3'b101) begin
          if (f7_alt) dec_d.alu_ctrl = ALU_SRA;
          else if (!f7_base) illegal_d = 1'b1;
        end
      end
      OPC_BRANCH: begin
        dec_d.branch = 1'b1;
        imm_src_d    = IMM_B;
        case (bus.funct3[2:1])
          2'b00:   dec_d.alu_ctrl = ALU_SUB;
          2'b10:   dec_d.alu_ctrl = ALU_SLT;
          2'b11:   dec_d.alu_ctrl = ALU_SLTU;
          default: illegal_d = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec_d.reg_write  = 1'b1;
        dec_d.result_src = 2'b10;
        dec_d.jump       = 1'b1;
        imm_src_d        = IMM_J;
      end
      OPC_JALR: begin
        dec_d.reg_write  = 1'b1;
        dec_d.result_src = 2'b10;
        dec_d.jump       = 1'b1;
        dec_d.jump_reg   = 1'b1;
        dec_d.alu_src    = 1'b1;
      end
      OPC_LUI: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_src   = 1'b1;
        dec_d.alu_ctrl  = ALU_PASSB;
        imm_src_d       = IMM_U;
      end
      OPC_AUIPC: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_src   = 1'b1;
        dec_d.src_a_src = 1'b1;
        imm_src_d       = IMM_U;
      end
      default: illegal_d = 1'b1;
    endcase
    if (illegal_d) begin
      dec_d     = '0;
      imm_src_d = IMM_I;
`ifdef MEXT_EN
      md_sel_dec = 1'b0;
      md_op_dec  = 3'b000;
`endif
    end
  end

  // E/M/W next state: flush beats hold beats load; a held E sends a bubble to M
  always_comb begin
    hold_e = bus.StallE | md_stall;
    e_d    = e_q;
    if (bus.FlushE) e_d = '0;
    else if (!hold_e) e_d = dec_d;
    m_d = (md_stall || (bus.StallE && !bus.FlushE)) ? 4'b0000
        : {e_q.reg_write, e_q.result_src, e_q.mem_write};
    w_d = m_q[3:1];
`ifdef MEXT_EN
    md_sel_d = md_sel_q;
    md_op_d  = md_op_q;
    if (bus.FlushE) begin
      md_sel_d = 1'b0;
      md_op_d  = 3'b000;
    end else if (!hold_e) begin
      md_sel_d = md_sel_dec;
      md_op_d  = md_op_dec;
    end
`endif
  end

  // pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

`ifdef MEXT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} div_state_t;
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);
  div_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // divider sequencing: the entry cycle and every BUSY cycle stall, DONE releases the op
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_sel_q && md_op_q[2] && !bus.FlushE) begin
          md_stall = 1'b1;
          cnt_d    = DIV_LOAD;
          state_d  = (DIV_CYCLES == 2) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        md_stall = 1'b1;
        if (bus.FlushE) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
          if (cnt_q <= 8'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.FlushE || !bus.StallE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // divider state, counter and E-stage M-op fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      md_sel_q <= 1'b0;
      md_op_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      md_sel_q <= md_sel_d;
      md_op_q  <= md_op_d;
    end
  end

  assign bus.MdSelE        = md_sel_q;
  assign bus.MdOpE         = md_op_q;
  assign bus.div_state_dbg = state_q;
`else
  assign md_stall          = 1'b0;
  assign bus.MdSelE        = 1'b0;
  assign bus.MdOpE         = 3'b000;
  assign bus.div_state_dbg = 2'd0;
`endif

  assign bus.IllegalD    = illegal_d;
  assign bus.ImmSrcD     = imm_src_d;
  assign bus.RegWriteE   = e_q.reg_write;
  assign bus.ResultSrcE  = e_q.result_src;
  assign bus.MemWriteE   = e_q.mem_write;
  assign bus.JumpE       = e_q.jump;
  assign bus.BranchE     = e_q.branch;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.SrcAsrcE    = e_q.src_a_src;
  assign bus.jumpRegE    = e_q.jump_reg;
  assign bus.ALUControlE = e_q.alu_ctrl;
  assign bus.RegWriteM   = m_q[3];
  assign bus.ResultSrcM  = m_q[2:1];
  assign bus.MemWriteM   = m_q[0];
  assign bus.RegWriteW   = w_q[2];
  assign bus.ResultSrcW  = w_q[1:0];
  assign bus.MdStall     = md_stall;
endmodule
